// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operation encoding and the
// decoded control bundle carried from decode to register-read.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // M-extension ops occupy 10..17 so that funct3 maps onto them by offset.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLTU   = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic [2:0]  branch_type;
    logic        jump;
    logic        illegal;
  } decode_ctrl_t;

  // Base integer ALU op from funct3; alt (funct7[5]) picks SUB / SRA.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// DEPTH-entry synchronous FIFO with flush and occupancy count.
// Head data is read combinationally so the decoder sees it in the same cycle.
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_en;
  logic             pop_en;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign push_en  = push && !full && !flush;
  assign pop_en   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Buffered RV32I decode stage: FIFO of {pc, instr}, combinational decode of
// the head entry, registered valid/ready output slot.
// Optional RV32M decode is enabled by defining DECODE_RV32M_EN.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output decode_ctrl_t     out_ctrl,
  output logic [CNT_W-1:0] count
);

  logic [63:0]  head_data;
  logic [31:0]  head_pc;
  logic [31:0]  instr;
  logic         fifo_full;
  logic         fifo_empty;
  logic         slot_free;
  logic         pop;
  logic         push;
  decode_ctrl_t dec;
  logic         illegal;
  logic [6:0]   opcode;
  logic [2:0]   f3;
  logic [6:0]   f7;

  logic         out_valid_reg;
  logic [31:0]  out_pc_reg;
  decode_ctrl_t out_ctrl_reg;

  assign in_ready  = !fifo_full && !flush;
  assign push      = in_valid && in_ready;
  assign slot_free = !out_valid_reg || out_ready;
  assign pop       = slot_free && !fifo_empty;

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({in_pc, in_instr}),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_pc = head_data[63:32];
  assign instr   = head_data[31:0];
  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];

  // Decode the FIFO head into the control bundle, flagging illegal encodings.
  always_comb begin
    dec         = '0;
    illegal     = 1'b0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.alu_op  = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_op = alu_from_funct3(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000 || f3 == 3'b101) dec.alu_op = alu_from_funct3(f3, 1'b1);
          else illegal = 1'b1;
        end
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          dec.alu_op = alu_op_e'(5'd10 + {2'b00, f3});
        end
`endif
        else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b001: begin
            dec.alu_op = ALU_SLL;
            if (f7 != 7'b0000000) illegal = 1'b1;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      dec.alu_op = ALU_SRL;
            else if (f7 == 7'b0100000) dec.alu_op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: dec.alu_op = alu_from_funct3(f3, 1'b0);
        endcase
      end
      OPC_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.imm        = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        dec.alu_op      = ALU_SUB;
        dec.branch      = 1'b1;
        dec.branch_type = f3;
        dec.imm         = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = {{20{instr[31]}}, instr[31:20]};
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = {instr[31:12], 12'b0};
      end
      OPC_MISC_MEM: begin
        // FENCE has no effect on this in-order pipeline: plain NOP bundle.
        dec = '0;
      end
      default: illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11 || instr == 32'h0) illegal = 1'b1;
    // Illegal entries still flow downstream but must not change state.
    if (illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
    dec.illegal = illegal;
  end

  // Output slot: load the decoded head whenever the slot is free, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_pc_reg    <= '0;
      out_ctrl_reg  <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (slot_free) begin
      if (!fifo_empty) begin
        out_valid_reg <= 1'b1;
        out_pc_reg    <= head_pc;
        out_ctrl_reg  <= dec;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_pc    = out_pc_reg;
  assign out_ctrl  = out_ctrl_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected decode results are queued at
// push time and compared when the output slot hands an entry over.
module tb_decode_stage;
  import riscv_pkg::*;

  localparam logic [15:0] M_FULL = 16'hFFFF;
  localparam logic [15:0] M_SIDE = 16'h03A3;  // reg_write,mem_read,mem_write,branch,jump,illegal
  localparam logic [15:0] M_NOOP = 16'h03FF;  // everything except alu_op/alu_src
  localparam logic [15:0] F_ILL  = 16'h0001;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pc;
  logic [31:0]  in_instr;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc;
  decode_ctrl_t out_ctrl;
  logic [2:0]   count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [15:0] flags;
    logic [15:0] fmask;
    bit          chk_imm;
    bit          chk_rd;
  } exp_t;

  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   cyc = 0;

  decode_stage #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_ctrl  (out_ctrl),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic src, input logic rw,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic br, input logic [2:0] bt, input logic j,
                                     input logic il);
    return {op, src, rw, mr, mw, m2r, br, bt, j, il};
  endfunction

  // Offer one entry; queue its expectation in the cycle it is accepted.
  task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] imm,
                      input logic [4:0] rd, input logic [15:0] flags, input logic [15:0] fmask,
                      input bit chk_imm, input bit chk_rd);
    exp_t e;
    bit   done = 0;
    e.pc = pc; e.imm = imm; e.rd = rd; e.flags = flags; e.fmask = fmask;
    e.chk_imm = chk_imm; e.chk_rd = chk_rd;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("push_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain(input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: one line per delivered entry, compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [15:0] got_flags;
      exp_t e;
      got_flags = {out_ctrl.alu_op, out_ctrl.alu_src, out_ctrl.reg_write, out_ctrl.mem_read,
                   out_ctrl.mem_write, out_ctrl.mem_to_reg, out_ctrl.branch,
                   out_ctrl.branch_type, out_ctrl.jump, out_ctrl.illegal};
      xfer_cyc.push_back(cyc);
      $display("xfer pc=%08h imm=%08h rd=%0d flags=%04h", out_pc, out_ctrl.imm, out_ctrl.rd, got_flags);
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pc", 64'(out_pc), 64'(e.pc));
        check($sformatf("flags@%08h", e.pc), 64'(got_flags & e.fmask), 64'(e.flags & e.fmask));
        if (e.chk_imm) check($sformatf("imm@%08h", e.pc), 64'(out_ctrl.imm), 64'(e.imm));
        if (e.chk_rd)  check($sformatf("rd@%08h", e.pc), 64'(out_ctrl.rd), 64'(e.rd));
      end
    end
  end

  initial begin
    logic [15:0] f_addi;
    f_addi    = mk(ALU_ADD, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0);
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-edge latency for addi x1,x0,5.
    push(32'h100, 32'h00500093, 32'd5, 5'd1, f_addi, M_FULL, 1, 1);
    in_valid = 1'b0;
    check("lat_edge1_valid", 64'(out_valid), 64'd0);
    check("lat_edge1_count", 64'(count), 64'd1);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drain(10);

    // Fill: slot plus four FIFO entries, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(32'h200 + 32'(4 * i), (32'(i) << 20) | 32'h00000093, 32'(i), 5'd1, f_addi, M_FULL, 1, 1);
    in_valid = 1'b0;
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_hold_pc", 64'(out_pc), 64'h200);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("after_pop_in_ready", 64'(in_ready), 64'd1);
    check("after_pop_count", 64'(count), 64'd3);
    drain(20);

    // Decode patterns, including illegal encodings and FENCE.
    push(32'h300, 32'hFFFFFFFF, '0, '0, F_ILL, M_SIDE, 0, 0);
    push(32'h304, 32'h00000000, '0, '0, F_ILL, M_SIDE, 0, 0);
    push(32'h308, 32'h407302B3, '0, 5'd5, mk(ALU_SUB, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0), M_FULL, 0, 1);
    push(32'h30C, 32'hFFC12203, 32'hFFFFFFFC, 5'd4, mk(ALU_ADD, 1, 1, 1, 0, 1, 0, 3'd0, 0, 0), M_FULL, 1, 1);
    push(32'h310, 32'h12345337, 32'h12345000, 5'd6, mk(ALU_ADD, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0), M_FULL, 1, 1);
    push(32'h314, 32'h010000EF, 32'd16, 5'd1, mk(ALU_ADD, 0, 1, 0, 0, 0, 0, 3'd0, 1, 0), M_NOOP, 1, 1);
    push(32'h318, 32'h40345393, '0, 5'd7, mk(ALU_SRA, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0), M_FULL, 0, 1);
    push(32'h31C, 32'h407312B3, '0, '0, F_ILL, M_SIDE, 0, 0);
    push(32'h320, 32'hFE20ACE3, '0, '0, F_ILL, M_SIDE, 0, 0);
    push(32'h324, 32'h000110E7, '0, '0, F_ILL, M_SIDE, 0, 0);
    push(32'h328, 32'h40309093, '0, '0, F_ILL, M_SIDE, 0, 0);
    push(32'h32C, 32'h0FF0000F, 32'd0, 5'd0, 16'h0000, M_FULL, 1, 1);
`ifdef DECODE_RV32M_EN
    push(32'h330, 32'h022081B3, '0, 5'd3, mk(ALU_MUL, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0), M_FULL, 0, 1);
`else
    push(32'h330, 32'h022081B3, '0, '0, F_ILL, M_SIDE, 0, 0);
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);

    // Flush with three buffered entries, a full slot and a concurrent push.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'h400 + 32'(4 * i), 32'h00500093, 32'd5, 5'd1, f_addi, M_FULL, 1, 1);
    check("preflush_count", 64'(count), 64'd3);
    check("preflush_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_pc    = 32'h4F0;
    in_instr = 32'h00500093;
    flush    = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("flush_discard_valid", 64'(out_valid), 64'd0);
    check("flush_discard_count", 64'(count), 64'd0);

    // Asynchronous reset mid-cycle clears a held entry at once.
    push(32'h500, 32'h00500093, 32'd5, 5'd1, f_addi, M_FULL, 1, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_pc", 64'(out_pc), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Stream of 20 alternating beq / sw at full rate.
    out_ready = 1'b1;
    xfer_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        push(32'h600 + 32'(4 * i), 32'hFE208CE3, 32'hFFFFFFF8, '0,
             mk(ALU_SUB, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0), M_FULL, 1, 0);
      else
        push(32'h600 + 32'(4 * i), 32'h0020A623, 32'd12, '0,
             mk(ALU_ADD, 1, 0, 0, 1, 0, 0, 3'd0, 0, 0), M_FULL, 1, 0);
    end
    in_valid = 1'b0;
    drain(20);
    check("stream_xfers", 64'(xfer_cyc.size()), 64'd20);
    if (xfer_cyc.size() == 20)
      check("stream_span", 64'(xfer_cyc[19] - xfer_cyc[0]), 64'd19);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
